// File: rtl/lane_game_core.sv
// lane_game_core -- scrolling lane-dodging game engine.
//
// The player occupies one lane of the bottom row of an obstacle field that scrolls
// down one row every TICK_DIV clock cycles. Each step survived adds one to the score.
// Reaching WIN_SCORE wins the game. Overlapping an obstacle in the bottom row loses it.
//
// Ports:
//   CLK         system clock, rising edge
//   resetn      asynchronous active-low reset
//   start       level start from IDLE; its rising edge leaves LOST/WON
//   abort       synchronous return to IDLE from any state
//   pause       freezes play while high
//   move_left   single-cycle request to move one lane toward lane 0
//   move_right  single-cycle request to move one lane toward lane LANES-1
//   spawn_rand  candidate obstacle row, loaded into row 0 on each step
//   player_lane one-hot player lane (registered)
//   field       obstacle map, row r at bits [r*LANES +: LANES] (registered)
//   score       steps survived (registered)
//   state       0=IDLE 1=PLAY 2=LOST 3=WON (registered)
//   step_pulse  one-cycle pulse per committed scroll step (registered)
//   crash       one-cycle pulse on entry to LOST (registered)
module lane_game_core #(
  parameter int LANES     = 3,
  parameter int DEPTH     = 8,
  parameter int TICK_DIV  = 50000000,
  parameter int SCORE_W   = 10,
  parameter int WIN_SCORE = 999
) (
  input  logic                     CLK,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     pause,
  input  logic                     move_left,
  input  logic                     move_right,
  input  logic [LANES-1:0]         spawn_rand,
  output logic [LANES-1:0]         player_lane,
  output logic [DEPTH*LANES-1:0]   field,
  output logic [SCORE_W-1:0]       score,
  output logic [1:0]               state,
  output logic                     step_pulse,
  output logic                     crash
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [LANES-1:0]   HOME_LANE = {{(LANES-1){1'b0}}, 1'b1} << (LANES / 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_LOST = 2'd2,
    S_WON  = 2'd3
  } state_t;

  state_t                   r_state;
  logic [LANES-1:0]         r_player;
  logic [DEPTH*LANES-1:0]   r_field;
  logic [SCORE_W-1:0]       r_score;
  logic [TW-1:0]            r_tick;
  logic                     r_step_pulse;
  logic                     r_crash;
  logic                     r_start_d;

  logic                     w_start_rise;
  logic                     w_step;
  logic [LANES-1:0]         w_spawn;
  logic [LANES-1:0]         w_player_nxt;
  logic [DEPTH*LANES-1:0]   w_field_nxt;
  logic                     w_hit;
  logic [SCORE_W-1:0]       w_score_inc;
  logic [TW-1:0]            w_tick_nxt;
  logic                     w_go_idle;

  assign player_lane = r_player;
  assign field       = r_field;
  assign score       = r_score;
  assign state       = r_state;
  assign step_pulse  = r_step_pulse;
  assign crash       = r_crash;

  // Next-state candidates for one unpaused PLAY cycle, plus the IDLE-load condition.
  always_comb begin
    w_start_rise = start & ~r_start_d;
    w_step       = (r_tick == TICK_LAST);
    w_tick_nxt   = w_step ? '0 : r_tick + TW'(1);
    w_score_inc  = r_score + SCORE_W'(1);

    // A full row would leave no path; opening the rightmost lane keeps one free.
    if (&spawn_rand) begin
      w_spawn = {1'b0, spawn_rand[LANES-2:0]};
    end else begin
      w_spawn = spawn_rand;
    end

    // Opposing requests cancel; edge lanes saturate.
    if (move_left && !move_right && !r_player[0]) begin
      w_player_nxt = r_player >> 1;
    end else if (move_right && !move_left && !r_player[LANES-1]) begin
      w_player_nxt = r_player << 1;
    end else begin
      w_player_nxt = r_player;
    end

    if (w_step) begin
      w_field_nxt = {r_field[(DEPTH-1)*LANES-1:0], w_spawn};
    end else begin
      w_field_nxt = r_field;
    end

    // Collision is judged on the post-move, post-scroll picture, so moving
    // sideways into an obstacle already in the bottom row also loses.
    w_hit = |(w_field_nxt[(DEPTH-1)*LANES +: LANES] & w_player_nxt);

    case (r_state)
      S_IDLE:  w_go_idle = 1'b1;
      S_PLAY:  w_go_idle = abort;
      S_LOST:  w_go_idle = abort | w_start_rise;
      S_WON:   w_go_idle = abort | w_start_rise;
      default: w_go_idle = 1'b1;
    endcase
  end

  // Game state machine, playfield, score, tick counter and output pulses.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_player     <= HOME_LANE;
      r_field      <= '0;
      r_score      <= '0;
      r_tick       <= '0;
      r_step_pulse <= 1'b0;
      r_crash      <= 1'b0;
      r_start_d    <= 1'b0;
    end else begin
      r_start_d    <= start;
      r_step_pulse <= 1'b0;
      r_crash      <= 1'b0;
      if (w_go_idle) begin
        // Only a non-aborted IDLE cycle with start high launches play.
        if ((r_state == S_IDLE) && start && !abort) begin
          r_state <= S_PLAY;
        end else begin
          r_state <= S_IDLE;
        end
        r_player <= HOME_LANE;
        r_field  <= '0;
        r_score  <= '0;
        r_tick   <= '0;
      end else begin
        case (r_state)
          S_PLAY: begin
            if (!pause) begin
              r_tick   <= w_tick_nxt;
              r_player <= w_player_nxt;
              r_field  <= w_field_nxt;
              if (w_hit) begin
                // Loss wins over a simultaneous step or win; score is not credited.
                r_state <= S_LOST;
                r_crash <= 1'b1;
              end else if (w_step) begin
                r_score      <= w_score_inc;
                r_step_pulse <= 1'b1;
                if (w_score_inc == WIN_VAL) begin
                  r_state <= S_WON;
                end else begin
                  r_state <= S_PLAY;
                end
              end else begin
                r_state <= S_PLAY;
              end
            end else begin
              r_state <= S_PLAY;
            end
          end
          S_LOST:  r_state <= S_LOST;
          S_WON:   r_state <= S_WON;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lane_game_core.sv
// Directed testbench for lane_game_core: a vector table for the main play flow
// plus hand-written sequences for crash, sideways collision, pause and reset.
// Instance a uses WIN_SCORE=5, instance b uses WIN_SCORE=15 for the long crash run.
module tb_lane_game_core;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        pause = 1'b0;
  logic        move_left = 1'b0;
  logic        move_right = 1'b0;
  logic [2:0]  spawn_rand = 3'b000;

  logic [2:0]  a_player, b_player;
  logic [23:0] a_field, b_field;
  logic [9:0]  a_score, b_score;
  logic [1:0]  a_state, b_state;
  logic        a_step, b_step, a_crash, b_crash;

  int total = 0;
  int bad   = 0;

  lane_game_core #(.LANES(3), .DEPTH(8), .TICK_DIV(4), .SCORE_W(10), .WIN_SCORE(5)) dut_a (
    .CLK(CLK), .resetn(resetn), .start(start), .abort(abort), .pause(pause),
    .move_left(move_left), .move_right(move_right), .spawn_rand(spawn_rand),
    .player_lane(a_player), .field(a_field), .score(a_score), .state(a_state),
    .step_pulse(a_step), .crash(a_crash)
  );

  lane_game_core #(.LANES(3), .DEPTH(8), .TICK_DIV(4), .SCORE_W(10), .WIN_SCORE(15)) dut_b (
    .CLK(CLK), .resetn(resetn), .start(start), .abort(abort), .pause(pause),
    .move_left(move_left), .move_right(move_right), .spawn_rand(spawn_rand),
    .player_lane(b_player), .field(b_field), .score(b_score), .state(b_state),
    .step_pulse(b_step), .crash(b_crash)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        st;
    logic        ml;
    logic        mr;
    logic [2:0]  sp;
    logic [1:0]  e_state;
    logic [2:0]  e_player;
    logic [23:0] e_field;
    logic [9:0]  e_score;
    logic        e_step;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; abort = 1'b0; pause = 1'b0;
    move_left = 1'b0; move_right = 1'b0; spawn_rand = 3'b000;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic add(input logic st, input logic ml, input logic mr, input logic [2:0] sp,
                     input logic [1:0] es, input logic [2:0] ep, input logic [23:0] ef,
                     input logic [9:0] esc, input logic estp);
    vec_t v;
    v.st = st; v.ml = ml; v.mr = mr; v.sp = sp;
    v.e_state = es; v.e_player = ep; v.e_field = ef; v.e_score = esc; v.e_step = estp;
    vq.push_back(v);
  endtask

  initial begin
    int steps;
    int seen;
    int pulses;

    // Main flow on instance a: start, first step, moves, win at score 5, leave WON, restart.
    add(1'b1, 1'b0, 1'b0, 3'b000, 2'd1, 3'b010, 24'h0, 10'd0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 3'b000, 2'd1, 3'b010, 24'h0, 10'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 2'd1, 3'b010, 24'h0, 10'd1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 3'b000, 2'd1, 3'b001, 24'h0, 10'd1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 3'b000, 2'd1, 3'b001, 24'h0, 10'd1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 3'b000, 2'd1, 3'b001, 24'h0, 10'd1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b010, 2'd1, 3'b001, 24'h000002, 10'd2, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 3'b000, 2'd1, 3'b001, 24'h000002, 10'd2, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 2'd1, 3'b001, 24'h000010, 10'd3, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 3'b000, 2'd1, 3'b001, 24'h000010, 10'd3, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 2'd1, 3'b001, 24'h000080, 10'd4, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 3'b000, 2'd1, 3'b001, 24'h000080, 10'd4, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 2'd3, 3'b001, 24'h000400, 10'd5, 1'b1);
    add(1'b0, 1'b0, 1'b0, 3'b000, 2'd3, 3'b001, 24'h000400, 10'd5, 1'b0);
    add(1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 3'b010, 24'h0, 10'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 3'b000, 2'd1, 3'b010, 24'h0, 10'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 3'b000, 2'd1, 3'b010, 24'h0, 10'd0, 1'b0);

    do_reset();
    chk("reset_state", 32'(a_state), 32'd0);
    chk("reset_player", 32'(a_player), 32'h2);
    chk("reset_field", 32'(a_field), 32'h0);
    chk("reset_score", 32'(a_score), 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      start = vq[i].st; move_left = vq[i].ml; move_right = vq[i].mr; spawn_rand = vq[i].sp;
      tick();
      chk($sformatf("v%0d_state", i),  32'(a_state),  32'(vq[i].e_state));
      chk($sformatf("v%0d_player", i), 32'(a_player), 32'(vq[i].e_player));
      chk($sformatf("v%0d_field", i),  32'(a_field),  32'(vq[i].e_field));
      chk($sformatf("v%0d_score", i),  32'(a_score),  32'(vq[i].e_score));
      chk($sformatf("v%0d_step", i),   32'(a_step),   32'(vq[i].e_step));
      chk($sformatf("v%0d_crash", i),  32'(a_crash),  32'd0);
    end

    // Full-row spawn on instance b: 3'b011 rows march down and hit the centre lane on step 8.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    spawn_rand = 3'b111;
    steps = 0;
    seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      tick();
      if (b_crash) seen = 1;
      else if (b_step) steps++;
    end
    chk("full_crash_seen", 32'(seen), 32'd1);
    chk("full_steps_before_crash", 32'(steps), 32'd7);
    chk("full_state", 32'(b_state), 32'd2);
    chk("full_score", 32'(b_score), 32'd7);
    chk("full_player", 32'(b_player), 32'h2);
    chk("full_field", 32'(b_field), 32'(24'o33333333));
    chk("full_step_on_crash", 32'(b_step), 32'd0);
    spawn_rand = 3'b000;
    move_left = 1'b1;
    tick();
    move_left = 1'b0;
    chk("lost_crash_once", 32'(b_crash), 32'd0);
    chk("lost_state_hold", 32'(b_state), 32'd2);
    chk("lost_score_hold", 32'(b_score), 32'd7);
    chk("lost_player_hold", 32'(b_player), 32'h2);
    chk("lost_field_hold", 32'(b_field), 32'(24'o33333333));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", 32'(b_state), 32'd0);
    chk("abort_player", 32'(b_player), 32'h2);
    chk("abort_field", 32'(b_field), 32'h0);
    chk("abort_score", 32'(b_score), 32'd0);

    // Sideways collision on instance b: obstacle reaches bottom row in lane 1, player steps into it.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      move_left = (c == 1);
      spawn_rand = (c == 4) ? 3'b010 : 3'b000;
      tick();
    end
    move_left = 1'b0;
    spawn_rand = 3'b000;
    chk("side_pre_state", 32'(b_state), 32'd1);
    chk("side_pre_field", 32'(b_field), 32'h400000);
    chk("side_pre_score", 32'(b_score), 32'd8);
    chk("side_pre_player", 32'(b_player), 32'h1);
    move_right = 1'b1;
    tick();
    move_right = 1'b0;
    chk("side_crash", 32'(b_crash), 32'd1);
    chk("side_state", 32'(b_state), 32'd2);
    chk("side_player", 32'(b_player), 32'h2);
    chk("side_score", 32'(b_score), 32'd8);
    chk("side_step", 32'(b_step), 32'd0);

    // Pause: counter at 2 is held for 10 cycles, moves ignored, then resumes at 2.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    pause = 1'b1;
    move_left = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (a_step) pulses++;
    end
    chk("pause_no_step", 32'(pulses), 32'd0);
    chk("pause_player", 32'(a_player), 32'h2);
    chk("pause_score", 32'(a_score), 32'd0);
    chk("pause_state", 32'(a_state), 32'd1);
    pause = 1'b0;
    move_left = 1'b0;
    tick();
    chk("resume_no_step_yet", 32'(a_step), 32'd0);
    tick();
    chk("resume_step", 32'(a_step), 32'd1);
    chk("resume_score", 32'(a_score), 32'd1);

    // Asynchronous reset while step_pulse is high, then release with start already high.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("mid_step_pulse", 32'(a_step), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_state", 32'(a_state), 32'd0);
    chk("async_step", 32'(a_step), 32'd0);
    chk("async_score", 32'(a_score), 32'd0);
    chk("async_player", 32'(a_player), 32'h2);
    chk("async_field", 32'(a_field), 32'h0);
    start = 1'b1;
    @(posedge CLK);
    #3;
    resetn = 1'b1;
    tick();
    chk("release_start_level", 32'(a_state), 32'd1);
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_game_core.md
LANE_GAME_CORE -- requirements
Module: lane_game_core

Interface
REQ-001 Parameter LANES, default 3, number of lanes (>=2); lane 0 leftmost.
REQ-002 Parameter DEPTH, default 8, obstacle rows; row 0 top, row DEPTH-1 is the player row.
REQ-003 Parameter TICK_DIV, default 50000000, clock cycles per scroll step (>=2).
REQ-004 Parameter SCORE_W, default 10, score width.
REQ-005 Parameter WIN_SCORE, default 999, winning score (1 <= WIN_SCORE < 2^SCORE_W).
REQ-006 CLK  input  1  single system clock, rising edge.
REQ-007 resetn  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  level, sampled each cycle; IDLE->PLAY, LOST/WON->IDLE.
REQ-009 abort  input  1  synchronous return to IDLE from any state.
REQ-010 pause  input  1  level; freezes PLAY.
REQ-011 move_left, move_right  input  1 each  single-cycle move requests.
REQ-012 spawn_rand  input  LANES  candidate obstacle row, sampled on step cycles.
REQ-013 player_lane  output  LANES  one-hot player position, registered.
REQ-014 field  output  DEPTH*LANES  obstacle map; row r at bits [r*LANES +: LANES], registered.
REQ-015 score  output  SCORE_W  steps survived, registered.
REQ-016 state  output  2  IDLE=0, PLAY=1, LOST=2, WON=3.
REQ-017 step_pulse  output  1  high one cycle on each committed scroll step.
REQ-018 crash  output  1  high one cycle on the edge that enters LOST.

Function
REQ-019 IDLE: player_lane = one-hot bit LANES/2 (integer division), field = 0, score = 0, tick counter = 0.
REQ-020 IDLE with start=1 -> PLAY next edge; start must fall and rise again before PLAY->IDLE->PLAY is re-triggered (start is edge-detected for LOST/WON->IDLE only).
REQ-021 PLAY with pause=1: tick counter, field, player and score hold; moves ignored.
REQ-022 PLAY, pause=0: tick counter counts 0..TICK_DIV-1, wraps to 0; step cycle = counter at TICK_DIV-1.
REQ-023 Move: move_left alone shifts player one lane toward 0; move_right alone toward LANES-1; saturating at edges; both asserted = no move.
REQ-024 Step: field shifts one row down, row DEPTH-1 discarded, row 0 <= spawn_rand; if spawn_rand all ones, bit LANES-1 forced 0 (path always exists).
REQ-025 Collision: each PLAY cycle, compute next player (after move) and next field (after step if step cycle); if next row DEPTH-1 AND next player != 0 -> state LOST, crash=1 for one cycle, field/player update committed, score not incremented.
REQ-026 Step without collision: score+1, step_pulse=1; if new score == WIN_SCORE -> state WON on same edge.
REQ-027 Collision and win on same step: LOST takes priority.
REQ-028 LOST/WON: field, player, score frozen; step_pulse, crash = 0; rising edge of start -> IDLE.
REQ-029 abort=1 overrides all other inputs in any state: next edge IDLE values per REQ-019.
REQ-030 score never exceeds WIN_SCORE; no wrap.

Reset
REQ-031 resetn=0 asynchronously forces IDLE values (REQ-019), step_pulse=0, crash=0, edge detector cleared, regardless of state or mid-step.
REQ-032 First edge after resetn rises behaves as IDLE; start already high at release counts as a level (enters PLAY).

Verification (bench: LANES=3, DEPTH=8, TICK_DIV=4, WIN_SCORE=5)
REQ-033 Reset then start=1 one cycle -> state=1, player_lane=3'b010, field=0, score=0; step_pulse every 4th cycle.
REQ-034 spawn_rand=3'b111 held, player at 3'b010 -> each row 0 = 3'b011; after 8 steps bottom row 3'b011 hits player -> crash=1, state=2, score=7 (survived steps stop before 5 -> use WIN_SCORE=15 for this case).
REQ-035 spawn_rand=0, five steps -> score 1..5, state=3 on 5th step_pulse edge, score stays 5.
REQ-036 Player at 3'b001, move_left -> stays 3'b001; move_left+move_right same cycle -> unchanged; move_right into occupied bottom cell 3'b010 -> crash=1 next edge without step.
REQ-037 pause=1 for 10 cycles mid-PLAY -> no step_pulse, counter resumes at held value; abort in LOST -> IDLE next edge; resetn=0 mid-step -> outputs at IDLE values immediately.
